// File: rtl/norm_pkg.sv
// -----------------------------------------------------------------------------
// norm_pkg
//   Shared types and derived-size helpers for the pixel normalizer.
//   - state_t          : frame controller states
//   - calc_n_pix       : pixels per cropped frame
//   - calc_recip_w     : width of the fixed-point reciprocal / divider dividend
//   - calc_max_out     : largest normalized output code
//   - calc_cnt_w       : width of a counter that must reach n_pix
// -----------------------------------------------------------------------------
package norm_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DIV,
    STREAM,
    DONE
  } state_t;

  function automatic int calc_n_pix(input int rows, input int cols);
    return rows * cols;
  endfunction

  function automatic int calc_recip_w(input int out_bw, input int frac_bits);
    return out_bw + frac_bits;
  endfunction

  function automatic int calc_max_out(input int out_bw);
    return (1 << out_bw) - 1;
  endfunction

  function automatic int calc_cnt_w(input int n_pix);
    return $clog2(n_pix + 1);
  endfunction

endpackage

// File: rtl/recip_divider.sv
// -----------------------------------------------------------------------------
// recip_divider
//   Sequential restoring divider: quotient = floor(dividend / divisor).
//   The first quotient bit is produced on the start cycle itself, so a
//   non-zero divide raises done DIVIDEND_W cycles after start is sampled.
//   A zero divisor returns quotient 0 with done on the following cycle.
//   Ports:
//     clk, srst  : clock, synchronous active-high reset
//     start      : begin a divide (operands sampled this cycle)
//     dividend   : DIVIDEND_W-bit numerator
//     divisor    : DIVISOR_W-bit denominator
//     done       : one-cycle pulse, quotient valid from this cycle on
//     quotient   : result, held until the next start
// -----------------------------------------------------------------------------
module recip_divider #(
  parameter int DIVIDEND_W = 24,
  parameter int DIVISOR_W  = 10
) (
  input  logic                  clk,
  input  logic                  srst,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  done,
  output logic [DIVIDEND_W-1:0] quotient
);

  localparam int CNT_W = $clog2(DIVIDEND_W + 1);

  logic [DIVISOR_W-1:0]  rem_r, divisor_r;
  logic [DIVIDEND_W-1:0] quo_r;
  logic [CNT_W-1:0]      cnt_r;
  logic                  busy_r;

  logic [DIVISOR_W-1:0]  src_rem, src_div, next_rem;
  logic [DIVIDEND_W-1:0] src_quo, next_quo;
  logic [DIVISOR_W:0]    trial;

  // One restoring step. On the start cycle it works straight from the
  // operand ports so no cycle is spent just loading them.
  // NOTE: every always_comb output gets a value on every path (here the
  // unconditional assignments and the if/else pair), otherwise a latch is inferred.
  always_comb begin
    src_rem = start ? '0 : rem_r;
    src_quo = start ? dividend : quo_r;
    src_div = start ? divisor : divisor_r;
    trial   = {src_rem, src_quo[DIVIDEND_W-1]};
    if (trial >= {1'b0, src_div}) begin
      // Remainder stays below the divisor, so the narrowing is lossless.
      next_rem = DIVISOR_W'(trial - {1'b0, src_div});
      next_quo = {src_quo[DIVIDEND_W-2:0], 1'b1};
    end else begin
      next_rem = trial[DIVISOR_W-1:0];
      next_quo = {src_quo[DIVIDEND_W-2:0], 1'b0};
    end
  end

  // NOTE: clocked state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking (=) here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (srst) begin
      rem_r     <= '0;
      quo_r     <= '0;
      divisor_r <= '0;
      cnt_r     <= '0;
      busy_r    <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        divisor_r <= divisor;
        if (divisor == '0) begin
          rem_r  <= '0;
          quo_r  <= '0;
          cnt_r  <= '0;
          busy_r <= 1'b0;
          done   <= 1'b1;
        end else begin
          rem_r  <= next_rem;
          quo_r  <= next_quo;
          cnt_r  <= CNT_W'(DIVIDEND_W - 1);
          busy_r <= 1'b1;
        end
      end else if (busy_r) begin
        rem_r <= next_rem;
        quo_r <= next_quo;
        cnt_r <= cnt_r - 1'b1;
        if (cnt_r == CNT_W'(1)) begin
          busy_r <= 1'b0;
          done   <= 1'b1;
        end
      end
    end
  end

  assign quotient = quo_r;

endmodule

// File: rtl/pixel_normalizer.sv
// -----------------------------------------------------------------------------
// pixel_normalizer
//   Rescales a cropped pixel stream so the frame maximum maps to MAX_OUT.
//   Per frame: one reciprocal divide recip = floor(MAX_OUT*2^F / max), then a
//   2-stage multiply / round / saturate pipeline with AXI-Stream backpressure.
//   Ports:
//     clk, srst                 : clock, synchronous active-high reset
//     ap_start/ready/idle/done  : block-level handshake; max_value is sampled
//                                 on the accepted ap_start cycle
//     max_value                 : frame maximum from the crop stage
//     s_axis_*                  : input pixel stream (PIXEL_BIT_WIDTH)
//     m_axis_*                  : normalized output stream (OUT_BIT_WIDTH),
//                                 tlast on beat N_PIX
// -----------------------------------------------------------------------------
module pixel_normalizer
  import norm_pkg::*;
#(
  parameter int PIXEL_BIT_WIDTH = 10,
  parameter int OUT_ROWS        = 10,
  parameter int OUT_COLS        = 10,
  parameter int OUT_BIT_WIDTH   = 8,
  parameter int RECIP_FRAC_BITS = 16
) (
  input  logic                       clk,
  input  logic                       srst,
  input  logic                       ap_start,
  output logic                       ap_ready,
  output logic                       ap_idle,
  output logic                       ap_done,
  input  logic [PIXEL_BIT_WIDTH-1:0] max_value,
  input  logic                       s_axis_tvalid,
  output logic                       s_axis_tready,
  input  logic [PIXEL_BIT_WIDTH-1:0] s_axis_tdata,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  output logic [OUT_BIT_WIDTH-1:0]   m_axis_tdata,
  output logic                       m_axis_tlast
);

  localparam int N_PIX   = calc_n_pix(OUT_ROWS, OUT_COLS);
  localparam int RECIP_W = calc_recip_w(OUT_BIT_WIDTH, RECIP_FRAC_BITS);
  localparam int MAX_OUT = calc_max_out(OUT_BIT_WIDTH);
  localparam int CNT_W   = calc_cnt_w(N_PIX);
  localparam int PROD_W  = PIXEL_BIT_WIDTH + RECIP_W;

  localparam logic [RECIP_W-1:0] DIVIDEND   = RECIP_W'(MAX_OUT) << RECIP_FRAC_BITS;
  localparam logic [PROD_W:0]    ROUND_HALF = (PROD_W + 1)'(1) << (RECIP_FRAC_BITS - 1);
  localparam logic [PROD_W:0]    SAT_LIMIT  = (PROD_W + 1)'(MAX_OUT);
  localparam logic [CNT_W-1:0]   CNT_N_PIX  = CNT_W'(N_PIX);
  localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(N_PIX - 1);

  state_t state_r, state_nxt;

  logic                     div_start, div_done;
  logic [RECIP_W-1:0]       recip;
  logic [CNT_W-1:0]         in_cnt, out_cnt;
  logic                     stall, in_hs, out_hs;

  logic                     s1_valid;
  logic [PROD_W-1:0]        s1_prod;
  logic                     m_valid;
  logic [OUT_BIT_WIDTH-1:0] m_data;

  logic [PROD_W:0]          scaled;
  logic [OUT_BIT_WIDTH-1:0] sat_data;

  // The divider keeps its own copy of the divisor, which serves as the
  // latched frame maximum; its quotient is held untouched through STREAM.
  recip_divider #(
    .DIVIDEND_W (RECIP_W),
    .DIVISOR_W  (PIXEL_BIT_WIDTH)
  ) u_recip_divider (
    .clk      (clk),
    .srst     (srst),
    .start    (div_start),
    .dividend (DIVIDEND),
    .divisor  (max_value),
    .done     (div_done),
    .quotient (recip)
  );

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (srst) state_r <= IDLE;
    else      state_r <= state_nxt;
  end

  always_comb begin
    state_nxt = state_r;
    ap_ready  = 1'b0;
    ap_idle   = 1'b0;
    ap_done   = 1'b0;
    div_start = 1'b0;
    unique case (state_r)
      IDLE: begin
        ap_ready = 1'b1;
        ap_idle  = 1'b1;
        if (ap_start) begin
          div_start = 1'b1;
          state_nxt = DIV;
        end
      end
      DIV:    if (div_done) state_nxt = STREAM;
      STREAM: if (out_hs && m_axis_tlast) state_nxt = DONE;
      DONE: begin
        ap_done   = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------- handshakes
  // Both pipeline stages freeze together whenever the output is stalled,
  // which keeps m_axis_tdata/tlast stable and guarantees no beat is lost.
  assign stall         = m_valid && !m_axis_tready;
  assign s_axis_tready = (state_r == STREAM) && (in_cnt < CNT_N_PIX) && !stall;
  assign in_hs         = s_axis_tvalid && s_axis_tready;
  assign out_hs        = m_valid && m_axis_tready;

  always_ff @(posedge clk) begin
    if (srst || div_start) begin
      in_cnt  <= '0;
      out_cnt <= '0;
    end else begin
      if (in_hs)  in_cnt  <= in_cnt + 1'b1;
      if (out_hs) out_cnt <= out_cnt + 1'b1;
    end
  end

  // ------------------------------------------------------------ datapath
  // Round half up, then clamp: pixels above the frame maximum would
  // otherwise wrap past MAX_OUT.
  always_comb begin
    scaled   = ({1'b0, s1_prod} + ROUND_HALF) >> RECIP_FRAC_BITS;
    sat_data = (scaled > SAT_LIMIT) ? OUT_BIT_WIDTH'(MAX_OUT)
                                    : scaled[OUT_BIT_WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      s1_valid <= 1'b0;
      s1_prod  <= '0;
      m_valid  <= 1'b0;
      m_data   <= '0;
    end else if (!stall) begin
      s1_valid <= in_hs;
      if (in_hs) s1_prod <= PROD_W'(s_axis_tdata) * PROD_W'(recip);
      m_valid  <= s1_valid;
      if (s1_valid) m_data <= sat_data;
    end
  end

  assign m_axis_tvalid = m_valid;
  assign m_axis_tdata  = m_data;
  assign m_axis_tlast  = m_valid && (out_cnt == CNT_LAST);

endmodule
